// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: sequencer for ARM LDM/STM block transfers.
// Walks the register list from lowest to highest register and issues one word
// access per listed register. It drives the register file write port for
// loads, the read select for stores, and an optional base writeback.
// Optional feature macro: LDMSTM_ABORT_EN adds the mem_abort input and the
// aborted output.
module ldm_stm_seq #(
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clock,
  input  logic        not_reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic        pre,
  input  logic        wback,
  input  logic [3:0]  base_sel,
  input  logic [31:0] base_val,
  input  logic [15:0] reg_list,
  input  logic [31:0] pc_val,
  input  logic [31:0] rf_p0,
  input  logic [3:0]  flags_cur,
  output logic [3:0]  rf_sel_p0,
  output logic [3:0]  rf_sel_in,
  output logic [31:0] rf_in_reg,
  output logic [3:0]  rf_in_flags,
  output logic        rf_not_enable,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        pc_load,
  output logic [31:0] pc_data,
  output logic        busy,
`ifdef LDMSTM_ABORT_EN
  input  logic        mem_abort,
  output logic        aborted,
`endif
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  // Index of the lowest set bit; scanning downward lets the lowest bit win.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_e      state_q, state_d;
  logic        is_load_q, up_q, wb_en_q;
  logic [3:0]  base_sel_q;
  logic [31:0] base_val_q, addr_q, pc_data_q;
  logic [15:0] list_q;
  logic [4:0]  cnt_q;

  logic [31:0] step_s, span_start_s, span_q_s, first_addr_s;
  logic [4:0]  cnt_start_s;
  logic [3:0]  idx_s;
  logic [15:0] list_rest_s;
  logic        last_beat_s, wb_en_start_s, abort_s, beat_done_s;

  assign step_s        = 32'(ADDR_STEP);
  assign cnt_start_s   = popcount16(reg_list);
  assign span_start_s  = step_s * {27'd0, cnt_start_s};
  assign span_q_s      = step_s * {27'd0, cnt_q};
  assign idx_s         = lowest_set(list_q);
  assign list_rest_s   = list_q & (list_q - 16'd1);
  assign last_beat_s   = (list_rest_s == 16'd0);
  // A loaded base register wins over writeback; r15 is never written back.
  assign wb_en_start_s = wback & (base_sel != 4'd15) & ~(is_load & reg_list[base_sel]);
  assign rf_in_flags   = flags_cur;

`ifdef LDMSTM_ABORT_EN
  assign abort_s = mem_abort;
`else
  assign abort_s = 1'b0;
`endif
  // An abort overrides an ack arriving in the same cycle.
  assign beat_done_s = mem_ack & ~abort_s;

  // Lowest transfer address for each of the four addressing modes.
  always_comb begin
    case ({up, pre})
      2'b10:   first_addr_s = base_val;
      2'b11:   first_addr_s = base_val + step_s;
      2'b00:   first_addr_s = base_val - span_start_s + step_s;
      2'b01:   first_addr_s = base_val - span_start_s;
      default: first_addr_s = base_val;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (cnt_start_s == 5'd0) ? S_DONE : S_XFER;
        else       state_d = S_IDLE;
      end
      S_XFER: begin
        if (abort_s)                     state_d = S_DONE;
        else if (mem_ack && last_beat_s) state_d = wb_en_q ? S_WB : S_DONE;
        else                             state_d = S_XFER;
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer context: captured at start, then advanced once per completed beat.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      is_load_q  <= 1'b0;
      up_q       <= 1'b0;
      wb_en_q    <= 1'b0;
      base_sel_q <= 4'd0;
      base_val_q <= 32'd0;
      addr_q     <= 32'd0;
      list_q     <= 16'd0;
      cnt_q      <= 5'd0;
      pc_data_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            up_q       <= up;
            wb_en_q    <= wb_en_start_s;
            base_sel_q <= base_sel;
            base_val_q <= base_val;
            addr_q     <= first_addr_s;
            list_q     <= reg_list;
            cnt_q      <= cnt_start_s;
          end
        end
        S_XFER: begin
          if (beat_done_s) begin
            list_q <= list_rest_s;
            addr_q <= addr_q + step_s;
            if (is_load_q && idx_s == 4'd15) pc_data_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LDMSTM_ABORT_EN
  logic aborted_q;

  // Remember that the current transfer ended by abort; cleared on every new start.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset)                                aborted_q <= 1'b0;
    else if (state_q == S_IDLE && start)           aborted_q <= 1'b0;
    else if (state_q == S_XFER && abort_s)         aborted_q <= 1'b1;
    else                                           aborted_q <= aborted_q;
  end

  assign aborted = (state_q == S_DONE) & aborted_q;
`endif

  // Outputs decoded from the state and the current beat.
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    rf_sel_p0     = 4'd0;
    rf_sel_in     = 4'd0;
    rf_in_reg     = 32'd0;
    rf_not_enable = 1'b1;
    pc_load       = 1'b0;
    pc_data       = pc_data_q;
    case (state_q)
      S_XFER: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (!is_load_q) begin
          // The register file samples on negedge, so the select is valid from the first beat cycle.
          mem_we    = 1'b1;
          rf_sel_p0 = idx_s;
          mem_wdata = (idx_s == 4'd15) ? pc_val : rf_p0;
        end else if (beat_done_s) begin
          if (idx_s != 4'd15) begin
            rf_not_enable = 1'b0;
            rf_sel_in     = idx_s;
            rf_in_reg     = mem_rdata;
          end else begin
            pc_load = 1'b1;
            pc_data = mem_rdata;
          end
        end else begin
          rf_not_enable = 1'b1;
        end
      end
      S_WB: begin
        rf_not_enable = 1'b0;
        rf_sel_in     = base_sel_q;
        rf_in_reg     = up_q ? (base_val_q + span_q_s) : (base_val_q - span_q_s);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Multi-cycle sequencer for ARM LDM/STM (block transfer) instructions.
- Walks a 16-bit register list lowest-to-highest and issues one memory word access per listed register.
- Drives the register file write port for loads, the read select for stores, and optional base writeback.
- Sits in the execute stage beside the register file; the decoder starts it, and the pipeline stalls while busy=1.

Parameters:
- ADDR_STEP, 4, byte increment between consecutive transfer addresses.

Ports:
- clock  in  1  system clock; all state changes on posedge
- not_reset  in  1  asynchronous active-low reset
- start  in  1  launch a transfer; accepted only when busy=0
- is_load  in  1  1=LDM, 0=STM; captured at start
- up  in  1  1=increment, 0=decrement; captured at start
- pre  in  1  1=before (IB/DB), 0=after (IA/DA); captured at start
- wback  in  1  base writeback requested; captured at start
- base_sel  in  4  base register index; captured at start
- base_val  in  32  base register value; captured at start
- reg_list  in  16  register list; captured at start
- pc_val  in  32  value stored when r15 is in an STM list
- rf_p0  in  32  register file port 0 read data
- flags_cur  in  4  current flags, fed back unchanged
- rf_sel_p0  out  4  register file read select (STM data)
- rf_sel_in  out  4  register file write select
- rf_in_reg  out  32  register file write data
- rf_in_flags  out  4  always equal to flags_cur; keeps flags intact across writes
- rf_not_enable  out  1  register file write strobe, active low
- mem_req  out  1  memory request
- mem_we  out  1  1=store
- mem_addr  out  32  word address
- mem_wdata  out  32  store data
- mem_ack  in  1  access complete this cycle; may be high in the same cycle as mem_req
- mem_rdata  in  32  load data, valid when mem_ack=1
- pc_load  out  1  one-cycle pulse: load r15 from pc_data
- pc_data  out  32  mem_rdata captured for r15
- busy  out  1  high from the cycle after start through DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - state=IDLE
  - all outputs 0, except rf_not_enable=1 and rf_sel_*=0
  - rf_in_flags follows flags_cur combinationally
- States: IDLE -> XFER -> (WB) -> DONE -> IDLE.
- IDLE, start=1:
  - capture all start-time inputs; cnt = popcount(reg_list)
  - first address:
    - IA: base
    - IB: base+STEP
    - DA: base-STEP*cnt+STEP
    - DB: base-STEP*cnt
  - next state XFER; if cnt=0, go directly to DONE (no access, no writeback).
- XFER:
  - mem_req=1; mem_addr = current address; idx = lowest set bit of the remaining list.
  - Store: mem_we=1; rf_sel_p0=idx; mem_wdata = rf_p0, or pc_val when idx=15. The register file samples on negedge, so rf_sel_p0 is driven from the first XFER cycle.
  - mem_req, mem_addr and mem_wdata hold stable until mem_ack.
  - On mem_ack for a load:
    - idx<15: rf_not_enable=0, rf_sel_in=idx, rf_in_reg=mem_rdata, combinationally in that cycle.
    - idx=15: pc_load=1, pc_data=mem_rdata.
  - On mem_ack: clear idx from the list; address += STEP.
  - List empty after ack: go to WB if wback=1 and not suppressed, else DONE.
- Writeback suppression: LDM with base_sel in reg_list (the loaded value wins). Base_sel=15 is never written back.
- WB (one cycle): rf_not_enable=0, rf_sel_in=base_sel, rf_in_reg = base±STEP*cnt (+ if up, − if down). Arithmetic is mod 2^32; wrap-around is allowed.
- DONE: done=1 for one cycle, busy=1; next state IDLE.
- Outside the cycles listed above, rf_not_enable=1.
- start while busy=1 is ignored.
- Latency with zero-wait memory: 1 + cnt + (WB?1:0) + 1 cycles, counted from the start edge to done.
- Asynchronous reset mid-transfer: returns to IDLE immediately. The transfer is abandoned; no further rf or mem activity.

Optional Feature:
- Macro LDMSTM_ABORT_EN.
- Defined:
  - adds input mem_abort (1 bit) and output aborted (1 bit).
  - mem_abort=1 in XFER (takes priority over mem_ack) ends the transfer and goes to DONE.
  - No rf write for the aborting beat; no WB; aborted=1 alongside done.
  - Registers already loaded keep their values.
- Undefined: ports absent; transfers always run to completion.

Test Plan:
- STM IA, base r13=0x1000, list=0x0006, zero-wait ack -> two writes: 0x1000 <- r1, 0x1004 <- r2; with wback, r13=0x1008; done on cycle 5.
- LDM DB, base=0x2000, list=0x8011, wback=1 -> reads 0x1FF4->r0, 0x1FF8->r4, 0x1FFC->pc_load; base written back as 0x1FF4.
- LDM IA, base_sel=2, list=0x0004, wback=1 -> r2 = loaded value; no WB cycle; rf_in_flags = flags_cur on every write.
- mem_ack delayed 3 cycles per beat -> mem_addr and mem_wdata stable while waiting; exactly one rf write per ack.
- list=0x0000 -> no mem_req; done pulse 1 cycle after start. start while busy -> ignored.
- not_reset asserted mid-XFER -> busy=0, mem_req=0, rf_not_enable=1 immediately. With LDMSTM_ABORT_EN, mem_abort on beat 2 -> aborted=1, no writeback.
